event_packetizer: RTL
=====================

Name: event_packetizer

Overview:
- Consumer for the per-unit 2-bit event codes produced by processing_system on event_out_array.
- Detects new events, timestamps each one with a sample counter, and buffers the records in a FIFO.
- Delivers one record per transfer on a valid/ready stream, so events reach the readout path in hardware rather than only through a bench log.

Parameters:
- NUM_UNITS, 4, number of detection units; event_in width is 2*NUM_UNITS.
- TS_WIDTH, 16, sample timestamp counter width.
- FIFO_DEPTH, 16, record FIFO depth in entries; must be a power of two, at least 2.
- UNIT_W, $clog2(NUM_UNITS), unit index field width; derived, not overridable.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- sample_in_valid  in  1  one-cycle strobe per accepted sample; advances the timestamp.
- event_in  in  2*NUM_UNITS  unit u code at [2u+1:2u]; 2'b00 = no event.
- evt_valid  out  1  record available.
- evt_ready  in  1  downstream accepts the record.
- evt_data  out  TS_WIDTH+UNIT_W+2  record = {timestamp, unit index, code}.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  out  8  saturating count of lost events.

Behaviour:
- Reset (rst low, asynchronous): ts counter=0, prev codes=0, pending=0, FIFO empty, evt_valid=0, evt_data=0, fifo_level=0, drop_count=0.
- Timestamp: ts increments by 1 at each clk edge where sample_in_valid=1 and wraps modulo 2^TS_WIDTH.
  - An event is stamped with the ts value present in its detection cycle, before any same-cycle increment.
- New-event detect per unit u, in cycle N:
  - Condition: code != 0 and code != the registered previous code of u.
  - A held, unchanged nonzero code is not re-detected. A code returning to 0 is not an event.
- Pending slot per unit holds {ts, code} and a pending bit.
  - On detect, the slot is loaded at the end of cycle N.
  - If the slot is already pending and is not being drained that cycle: overwrite with the new data and increment drop_count, saturating at 255.
- Drain scanner:
  - Each cycle, when the FIFO is not full, select the lowest-index pending unit and write {ts, u, code} to the FIFO.
  - The selected unit's pending bit is cleared, unless a new detect for the same unit occurs in the same cycle. In that case the old data is written, the slot reloads with the new data, pending stays 1, and there is no drop.
  - At most one FIFO write per cycle.
  - FIFO full: the scanner stalls and pending slots hold.
- Latency: detect in cycle N -> FIFO write at end of N+1, given no contention and FIFO not full -> evt_valid=1 in cycle N+2.
- Output handshake:
  - evt_data is valid whenever evt_valid=1, and must stay stable until evt_ready=1 is sampled.
  - A transfer occurs when evt_valid & evt_ready at the clk edge.
  - When the FIFO is empty: evt_valid=0 and evt_data holds its last value.
- FIFO simultaneous read and write:
  - When full: allowed, level unchanged.
  - When empty: the write lands and the record appears the next cycle; no bypass.
- fifo_level is registered and updates in the same edge as the write or read.
- Reset mid-operation: all pending and FIFO contents are discarded immediately; no partial record is emitted.

Optional Feature:
- Macro EVENT_PACKETIZER_TS_WRAP_EN.
- Defined: when ts wraps from all-ones to 0, a marker record {ts=0, unit=0, code=2'b00} is queued.
  - The marker has priority over pending units for the next FIFO write slot.
  - If the FIFO is full, the marker waits in a single-entry holding flag. A second wrap while the flag is set increments drop_count.
- Undefined: no markers are generated; wrap is silent.

Test Plan:
- Reset release, unit 1 code 2'b01 for 1 cycle at ts=5, evt_ready=1 -> one record {5,1,01} with evt_valid high exactly 2 cycles after detect; drop_count=0.
- Units 0 and 3 both change to 2'b10 in the same cycle at ts=9 -> records {9,0,10} then {9,3,10} on consecutive cycles.
- Unit 2 holds 2'b01 for 50 cycles, then changes to 2'b11 -> exactly two records, codes 01 then 11.
- evt_ready=0, 20 detects on unit 0 spaced 3 cycles apart -> fifo_level saturates at 16; later detects overwrite the pending slot; drop_count=3; evt_ready=1 -> 17 records drain in order.
- 70000 sample strobes, TS_WIDTH=16 -> with EVENT_PACKETIZER_TS_WRAP_EN exactly one marker {0,0,00} after strobe 65536; without it no marker.
- Assert rst low while FIFO holds 5 records -> evt_valid=0 and fifo_level=0 asynchronously; nothing emitted after release until a new detect.

Source files
------------

// File: rtl/event_packetizer.sv
// event_packetizer: detects new per-unit event codes, timestamps them, buffers the records
// in a FIFO and streams them out on valid/ready. Define EVENT_PACKETIZER_TS_WRAP_EN for wrap markers.
module event_packetizer #(
    parameter int unsigned NUM_UNITS  = 4,
    parameter int unsigned TS_WIDTH   = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned UNIT_W    = $clog2(NUM_UNITS),
    localparam int unsigned REC_W     = TS_WIDTH + UNIT_W + 2,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_in_valid,
    input  logic [2*NUM_UNITS-1:0] event_in,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [REC_W-1:0]       evt_data,
    output logic [LVL_W-1:0]       fifo_level,
    output logic [7:0]             drop_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [1:0]           prev_q      [NUM_UNITS];
    logic [NUM_UNITS-1:0] pend_q, pend_d;
    logic [TS_WIDTH-1:0]  slot_ts_q   [NUM_UNITS];
    logic [TS_WIDTH-1:0]  slot_ts_d   [NUM_UNITS];
    logic [1:0]           slot_code_q [NUM_UNITS];
    logic [1:0]           slot_code_d [NUM_UNITS];
    logic [7:0]           drop_q, drop_d;
    logic                 marker_q, marker_d;

    logic [REC_W-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     count_q, count_d;
    logic                 valid_q, valid_d;
    logic [REC_W-1:0]     data_q, data_d;

    logic [NUM_UNITS-1:0] detect_c;
    logic [NUM_UNITS-1:0] drain_c;
    logic                 pop_c;
    logic                 can_wr_c;
    logic                 wr_en_c;
    logic                 marker_wr_c;
    logic                 wrap_c;
    logic                 sel_found_c;
    logic [UNIT_W-1:0]    sel_idx_c;
    logic [REC_W-1:0]     wr_data_c;
    logic [7:0]           drops_c;
    logic [8:0]           drop_sum_c;

`ifdef EVENT_PACKETIZER_TS_WRAP_EN
    assign wrap_c = sample_in_valid && (ts_q == '1);
`else
    assign wrap_c = 1'b0;
`endif

    // Detection, drain scanner, pending-slot update and drop accounting
    always_comb begin
        ts_d        = ts_q;
        pend_d      = pend_q;
        slot_ts_d   = slot_ts_q;
        slot_code_d = slot_code_q;
        marker_d    = marker_q;
        detect_c    = '0;
        drain_c     = '0;
        sel_found_c = 1'b0;
        sel_idx_c   = '0;
        marker_wr_c = 1'b0;
        wr_en_c     = 1'b0;
        wr_data_c   = '0;
        drops_c     = '0;
        drop_sum_c  = '0;
        pop_c       = valid_q && evt_ready;
        can_wr_c    = (count_q != LVL_W'(FIFO_DEPTH)) || pop_c;

        if (sample_in_valid) begin
            ts_d = ts_q + TS_WIDTH'(1);
        end

        for (int u = 0; u < int'(NUM_UNITS); u++) begin
            detect_c[u] = (event_in[2*u +: 2] != 2'b00) && (event_in[2*u +: 2] != prev_q[u]);
            if (pend_q[u] && !sel_found_c) begin
                sel_found_c = 1'b1;
                sel_idx_c   = UNIT_W'(u);
            end
        end

        // A queued wrap marker takes the write slot ahead of any pending unit
        if (can_wr_c) begin
            if (marker_q) begin
                marker_wr_c = 1'b1;
                wr_en_c     = 1'b1;
            end else if (sel_found_c) begin
                wr_en_c            = 1'b1;
                drain_c[sel_idx_c] = 1'b1;
                wr_data_c          = {slot_ts_q[sel_idx_c], sel_idx_c, slot_code_q[sel_idx_c]};
            end
        end

        for (int u = 0; u < int'(NUM_UNITS); u++) begin
            if (drain_c[u]) begin
                pend_d[u] = 1'b0;
            end
            if (detect_c[u]) begin
                if (pend_q[u] && !drain_c[u]) begin
                    drops_c = drops_c + 8'd1;
                end
                pend_d[u]      = 1'b1;
                slot_ts_d[u]   = ts_q;
                slot_code_d[u] = event_in[2*u +: 2];
            end
        end

        if (marker_wr_c) begin
            marker_d = 1'b0;
        end
        if (wrap_c) begin
            if (marker_q && !marker_wr_c) begin
                drops_c = drops_c + 8'd1;
            end
            marker_d = 1'b1;
        end

        drop_sum_c = {1'b0, drop_q} + {1'b0, drops_c};
        drop_d     = drop_sum_c[8] ? 8'hFF : drop_sum_c[7:0];
    end

    // FIFO pointers, occupancy and registered output head
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        valid_d  = 1'b0;

        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en_c, pop_c})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase

        valid_d = (count_d != '0);
        // The next head is the word being written only when nothing older remains
        if (valid_d) begin
            data_d = (wr_en_c && (wr_ptr_q == rd_ptr_d)) ? wr_data_c : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= wr_data_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q     <= '0;
            pend_q   <= '0;
            drop_q   <= '0;
            marker_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            for (int u = 0; u < int'(NUM_UNITS); u++) begin
                prev_q[u]      <= 2'b00;
                slot_ts_q[u]   <= '0;
                slot_code_q[u] <= 2'b00;
            end
        end else begin
            ts_q     <= ts_d;
            pend_q   <= pend_d;
            drop_q   <= drop_d;
            marker_q <= marker_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            for (int u = 0; u < int'(NUM_UNITS); u++) begin
                prev_q[u]      <= event_in[2*u +: 2];
                slot_ts_q[u]   <= slot_ts_d[u];
                slot_code_q[u] <= slot_code_d[u];
            end
        end
    end

    assign evt_valid  = valid_q;
    assign evt_data   = data_q;
    assign fifo_level = count_q;
    assign drop_count = drop_q;

endmodule
